// File: rtl/pulse_arbiter_pkg.sv
// Shared state encoding and default sizing for the pulse arbiter.
package pulse_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned CW_DEF    = 4;

endpackage

// File: rtl/pulse_arbiter_rr_select.sv
// Round-robin pick: first active requester after 'last', wrapping modulo N_REQ.
module rr_select
  import pulse_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned LW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_REQ-1:0] pick
);

  // Scan from last+1 upward; the first hit wins, so pick is at most one-hot.
  always_comb begin
    logic          found;
    logic [LW-1:0] w_idx;
    found = 1'b0;
    w_idx = '0;
    pick  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_idx = LW'((32'(last) + i) % N_REQ);
      if (!found && req[w_idx]) begin
        pick[w_idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter granting a shared pulse generator for limit+1 cycle bursts.
module pulse_arbiter
  import pulse_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] limit_i,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                out,
  output logic [CW-1:0]       count,
  output logic                busy
);

  localparam int unsigned LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state, w_state_d;
  logic [N_REQ-1:0] r_gnt, w_gnt_d;
  logic [N_REQ-1:0] r_done, w_done_d;
  logic             r_out, w_out_d;
  logic [CW-1:0]    r_count, w_count_d;
  logic             r_busy, w_busy_d;
  logic [CW-1:0]    r_lim, w_lim_d;
  logic [LW-1:0]    r_last, w_last_d;

  logic [N_REQ-1:0] w_pick;
  logic [CW-1:0]    w_pick_lim;
  logic [LW-1:0]    w_gnt_idx;

  rr_select #(
    .N_REQ (N_REQ),
    .LW    (LW)
  ) u_rr_select (
    .req  (req),
    .last (r_last),
    .pick (w_pick)
  );

  // Limit slice belonging to the requester about to be granted.
  always_comb begin
    w_pick_lim = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_lim = limit_i[i*CW +: CW];
    end
  end

  // Index of the requester currently holding the grant.
  always_comb begin
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) w_gnt_idx = LW'(i);
    end
  end

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_done_d  = '0;
    w_out_d   = r_out;
    w_count_d = r_count;
    w_busy_d  = r_busy;
    w_lim_d   = r_lim;
    w_last_d  = r_last;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_d = RUN;
          w_gnt_d   = w_pick;
          w_lim_d   = w_pick_lim;
          w_count_d = '0;
          w_out_d   = 1'b1;
          w_busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (r_count != r_lim) begin
          w_count_d = r_count + CW'(1);
        end else begin
          w_state_d = DONE;
          w_out_d   = 1'b0;
          w_gnt_d   = '0;
          w_done_d  = r_gnt;
          w_last_d  = w_gnt_idx;
        end
      end
      DONE: begin
        w_state_d = IDLE;
        w_busy_d  = 1'b0;
      end
      default: begin
        w_state_d = IDLE;
        w_gnt_d   = '0;
        w_out_d   = 1'b0;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks arbitration so requester 0 goes first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_out   <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_lim   <= '0;
      r_last  <= LW'(N_REQ - 1);
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_done  <= w_done_d;
      r_out   <= w_out_d;
      r_count <= w_count_d;
      r_busy  <= w_busy_d;
      r_lim   <= w_lim_d;
      r_last  <= w_last_d;
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign out   = r_out;
  assign count = r_count;
  assign busy  = r_busy;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter with hand-computed expectations.
module tb_pulse_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CW    = 4;

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*CW-1:0] limit_i;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                out;
  logic [CW-1:0]       count;
  logic                busy;

  int n_vec;
  int n_err;

  pulse_arbiter #(
    .N_REQ (N_REQ),
    .CW    (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .limit_i (limit_i),
    .gnt     (gnt),
    .done    (done),
    .out     (out),
    .count   (count),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic o, input logic [3:0] c, input logic b);
    chk({tag, ".gnt"},   32'(gnt),   32'(g));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".out"},   32'(out),   32'(o));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] g;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    req     = '0;
    limit_i = '0;
    #12;
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk_all("idle_after_reset", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);

    // All four requesting, all limits 0: order 0,1,2,3,0 with a 3-cycle period.
    req     = 4'b1111;
    limit_i = 16'h0000;
    tick();
    for (int b = 0; b < 5; b++) begin
      g = 4'b0001 << (b % 4);
      chk_all($sformatf("rr%0d.run", b), g, 4'b0000, 1'b1, 4'd0, 1'b1);
      tick();
      chk_all($sformatf("rr%0d.done", b), 4'b0000, g, 1'b0, 4'd0, 1'b1);
      tick();
      chk_all($sformatf("rr%0d.idle", b), 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
      if (b == 4) req = 4'b0000;
      tick();
    end
    chk_all("rr.stop", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);

    // Requester 0 with limit 3: four cycles of out, counting 0..3.
    req     = 4'b0001;
    limit_i = 16'h0003;
    tick();
    req = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      chk_all($sformatf("l3.c%0d", c), 4'b0001, 4'b0000, 1'b1, 4'(c), 1'b1);
      tick();
    end
    chk_all("l3.done", 4'b0000, 4'b0001, 1'b0, 4'd3, 1'b1);
    tick();
    chk_all("l3.idle1", 4'b0000, 4'b0000, 1'b0, 4'd3, 1'b0);
    tick();
    chk_all("l3.idle2", 4'b0000, 4'b0000, 1'b0, 4'd3, 1'b0);

    // Last served was 0, so 1001 grants 3 then 0.
    req     = 4'b1001;
    limit_i = 16'h0000;
    tick();
    chk_all("r1001.a", 4'b1000, 4'b0000, 1'b1, 4'd0, 1'b1);
    tick();
    chk_all("r1001.a_done", 4'b0000, 4'b1000, 1'b0, 4'd0, 1'b1);
    tick();
    tick();
    chk_all("r1001.b", 4'b0001, 4'b0000, 1'b1, 4'd0, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("r1001.b_done", 4'b0000, 4'b0001, 1'b0, 4'd0, 1'b1);
    tick();

    // Requester 2 at maximum limit: 16 cycles, counter stops at 15.
    req     = 4'b0100;
    limit_i = 16'h0F00;
    tick();
    req = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("l15.out%0d", c), 32'(out), 32'd1);
      chk($sformatf("l15.cnt%0d", c), 32'(count), 32'(c));
      tick();
    end
    chk_all("l15.done", 4'b0000, 4'b0100, 1'b0, 4'd15, 1'b1);
    tick();
    chk_all("l15.idle", 4'b0000, 4'b0000, 1'b0, 4'd15, 1'b0);

    // Requester 1, limit 2; limit change and req drop mid-burst are ignored.
    req     = 4'b0010;
    limit_i = 16'h0020;
    tick();
    chk_all("hold.c0", 4'b0010, 4'b0000, 1'b1, 4'd0, 1'b1);
    limit_i = 16'h0090;
    req     = 4'b0000;
    tick();
    chk_all("hold.c1", 4'b0010, 4'b0000, 1'b1, 4'd1, 1'b1);
    tick();
    chk_all("hold.c2", 4'b0010, 4'b0000, 1'b1, 4'd2, 1'b1);
    tick();
    chk_all("hold.done", 4'b0000, 4'b0010, 1'b0, 4'd2, 1'b1);
    tick();
    chk_all("hold.idle", 4'b0000, 4'b0000, 1'b0, 4'd2, 1'b0);

    // Reset at count 3 of a limit-5 burst aborts with no done pulse.
    req     = 4'b0001;
    limit_i = 16'h0005;
    tick();
    tick();
    tick();
    tick();
    chk_all("abort.c3", 4'b0001, 4'b0000, 1'b1, 4'd3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("abort.async", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
    tick();
    chk_all("abort.held", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    tick();
    chk_all("abort.regrant", 4'b0001, 4'b0000, 1'b1, 4'd0, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("abort.regrant_c1", 4'b0001, 4'b0000, 1'b1, 4'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_arbiter.md
PULSE_ARBITER -- requirements
Module: pulse_arbiter

Interface
REQ-001 Parameter N_REQ SHALL exist: default 4; number of requesters sharing the pulse generator.
REQ-002 Parameter CW SHALL exist: default 4; counter and limit width.
REQ-003 Port clk SHALL be input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit; asynchronous, active-low reset.
REQ-005 Port req SHALL be input, N_REQ bits; per-requester request level.
REQ-006 Port limit_i SHALL be input, N_REQ*CW bits; requester k's burst limit in bits [k*CW +: CW].
REQ-007 Port gnt SHALL be output, N_REQ bits; one-hot grant, high for the whole burst of the granted requester.
REQ-008 Port done SHALL be output, N_REQ bits; one-cycle completion pulse to the granted requester.
REQ-009 Port out SHALL be output, 1 bit; pulse-generator enable, high during the active burst.
REQ-010 Port count SHALL be output, CW bits; current burst counter value.
REQ-011 Port busy SHALL be output, 1 bit; high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE, with all outputs registered.
REQ-013 In IDLE with req != 0, the block SHALL grant one requester by round-robin, searching from (last+1) mod N_REQ upward, where last is the previously completed requester.
REQ-014 On that grant edge, the block SHALL set gnt to one-hot k, latch limit_i slice k into lim_q, clear count to 0, assert out, and enter RUN.
REQ-015 In RUN with count != lim_q, count SHALL increment by 1 per cycle.
REQ-016 In RUN with count == lim_q, the block SHALL deassert out and gnt, pulse done[k] for the next cycle, set last = k, and enter DONE.
REQ-017 Burst length SHALL be lim_q+1 cycles of out=1; limit 0 gives 1 cycle; limit 2^CW-1 gives 2^CW cycles with no counter wrap.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE; consecutive bursts SHALL be separated by at least 2 cycles of out=0.
REQ-019 req SHALL be sampled only in IDLE; dropping req during RUN SHALL NOT abort the burst.
REQ-020 Changes to limit_i during RUN SHALL be ignored, since lim_q is held.
REQ-021 With simultaneous requests, exactly one requester SHALL be granted per arbitration.
REQ-022 No requester with req held SHALL wait more than N_REQ-1 bursts.
REQ-023 gnt SHALL never be non-zero outside RUN, and done SHALL never have more than one bit set.
REQ-024 count SHALL hold its final value in DONE and IDLE until the next grant.

Reset
REQ-025 When rst=0, regardless of clk, the block SHALL set state=IDLE, gnt=0, done=0, out=0, count=0, busy=0, lim_q=0 and last=N_REQ-1, so requester 0 has first priority.
REQ-026 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release, arbitration SHALL restart from requester 0.
REQ-027 Deassertion of rst SHALL be synchronised by the system; the block SHALL NOT act on the first edge after release before sampling req.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default constants N_REQ_DEF=4 and CW_DEF=4.
REQ-029 The round-robin selector SHALL be one combinational sub-module, rr_select (inputs req and last; output one-hot pick), instantiated once.
REQ-030 The burst counter and FSM SHALL remain in pulse_arbiter.

Verification
REQ-031 Reset mid-RUN with req=0001 and limit0=5, asserted at count=3 -> all outputs 0 immediately; no done; after release with req=0001, gnt=0001 again.
REQ-032 req=0001, limit0=3 -> out high 4 cycles, count 0,1,2,3, done=0001 for 1 cycle, busy low 2 cycles after done.
REQ-033 req=1111 held, all limits 0 -> grant order 0,1,2,3,0, each burst 1 cycle of out, period 3 cycles.
REQ-034 req=0100, limit2=15 -> 16 cycles of out, count reaches 15 with no wrap, done=0100.
REQ-035 req=0010, limit1=2, with limit1 changed to 9 and req dropped at cycle 1 of RUN -> still 3 cycles of out and done=0010.
REQ-036 req=1001 after completing requester 0 -> next grant is 1000, then 0001.
